// File: rtl/vdp_sync_if.sv
// Signal bundle between vdp_sync_gen and the display pipeline:
// SMS-scaled counters, render/line/frame strobes and VGA sync/blank.
interface vdp_sync_if;
    logic       left_col_blank;
    logic [7:0] hpos;
    logic [7:0] vpos;
    logic [7:0] render_line;
    logic       render_start;
    logic       vblank_irq_pulse;
    logic       next_line;
    logic       hsync;
    logic       vsync;
    logic       border;
    logic       blank;

    modport master (
        input  left_col_blank,
        output hpos, vpos, render_line, render_start, vblank_irq_pulse,
               next_line, hsync, vsync, border, blank
    );

    modport slave (
        output left_col_blank,
        input  hpos, vpos, render_line, render_start, vblank_irq_pulse,
               next_line, hsync, vsync, border, blank
    );
endinterface

// File: rtl/vdp_sync_gen.sv
// 640x480 VGA timing generator that maps a centred 512x384 window onto SMS
// pixel/line indices (2x scaling). All outputs are registered decodes of the
// (hcnt, vcnt) position of the previous cycle.
module vdp_sync_gen #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_BORDER = 64,
    parameter int V_BORDER = 48
) (
    input  logic       clk,
    input  logic       reset_n,
    vdp_sync_if.master sync
);
    typedef logic [11:0] cnt_t;

    localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_WRAP    = cnt_t'(H_TOTAL - H_BORDER);
    localparam cnt_t V_WRAP    = cnt_t'(V_TOTAL - V_BORDER);
    localparam cnt_t H_BRD     = cnt_t'(H_BORDER);
    localparam cnt_t V_BRD     = cnt_t'(V_BORDER);
    localparam cnt_t H_ACT_END = cnt_t'(H_BORDER + 512);
    localparam cnt_t V_ACT_END = cnt_t'(V_BORDER + 384);
    localparam cnt_t H_LCB_END = cnt_t'(H_BORDER + 16);
    localparam cnt_t RS_FIRST  = cnt_t'(V_BORDER - 2);
    localparam cnt_t RS_LAST   = cnt_t'(V_BORDER - 2 + 382);
    localparam cnt_t HS_START  = 12'd656;
    localparam cnt_t HS_END    = 12'd752;
    localparam cnt_t VS_START  = 12'd490;
    localparam cnt_t VS_END    = 12'd492;
    localparam cnt_t H_VIS     = 12'd640;
    localparam cnt_t V_VIS     = 12'd480;

    typedef struct packed {
        logic [7:0] hpos;
        logic [7:0] vpos;
        logic [7:0] render_line;
        logic       render_start;
        logic       vblank_irq_pulse;
        logic       next_line;
        logic       hsync;
        logic       vsync;
        logic       border;
        logic       blank;
    } out_t;

    localparam out_t OUT_RESET = '{
        hpos: 8'h00, vpos: 8'h00, render_line: 8'h00,
        render_start: 1'b0, vblank_irq_pulse: 1'b0, next_line: 1'b0,
        hsync: 1'b1, vsync: 1'b1, border: 1'b1, blank: 1'b1
    };

    cnt_t hcnt_q, hcnt_d;
    cnt_t vcnt_q, vcnt_d;
    out_t out_q, out_d;
    cnt_t h_ofs, v_ofs, s_line, rs_diff;
    logic blank_c;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 12'd1;
        end
    end

    always_comb begin
        // Positions relative to the active window, wrapped into 0..TOTAL-1.
        h_ofs   = (hcnt_q >= H_BRD) ? hcnt_q - H_BRD : hcnt_q + H_WRAP;
        v_ofs   = (vcnt_q >= V_BRD) ? vcnt_q - V_BRD : vcnt_q + V_WRAP;
        s_line  = v_ofs >> 1;
        rs_diff = vcnt_q - RS_FIRST;
        blank_c = (hcnt_q >= H_VIS) || (vcnt_q >= V_VIS);

        out_d       = out_q;
        out_d.hpos  = 8'(h_ofs >> 1);
        // SMS V counter jumps back from 0xDA to 0xD5 after line 218.
        out_d.vpos  = (s_line <= 12'd218) ? 8'(s_line) : 8'(s_line - 12'd6);
        out_d.hsync = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        out_d.vsync = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
        out_d.blank = blank_c;
        out_d.border = !blank_c &&
                       ((hcnt_q < H_BRD) || (hcnt_q >= H_ACT_END) ||
                        (vcnt_q < V_BRD) || (vcnt_q >= V_ACT_END) ||
                        (sync.left_col_blank && (hcnt_q >= H_BRD) && (hcnt_q < H_LCB_END)));

        out_d.next_line        = (hcnt_q == '0) && !v_ofs[0] && (vcnt_q != '0);
        out_d.vblank_irq_pulse = out_d.next_line && (s_line == 12'd193);
        // Render request one SMS line ahead of display: two VGA lines early.
        out_d.render_start     = (hcnt_q == '0) && (vcnt_q >= RS_FIRST) &&
                                 (vcnt_q <= RS_LAST) && !rs_diff[0];
        if (out_d.render_start) begin
            out_d.render_line = 8'(rs_diff >> 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            out_q  <= OUT_RESET;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            out_q  <= out_d;
        end
    end

    assign sync.hpos             = out_q.hpos;
    assign sync.vpos             = out_q.vpos;
    assign sync.render_line      = out_q.render_line;
    assign sync.render_start     = out_q.render_start;
    assign sync.vblank_irq_pulse = out_q.vblank_irq_pulse;
    assign sync.next_line        = out_q.next_line;
    assign sync.hsync            = out_q.hsync;
    assign sync.vsync            = out_q.vsync;
    assign sync.border           = out_q.border;
    assign sync.blank            = out_q.blank;
endmodule
